// File: rtl/cam_axi_wr_if.sv
// AXI4 write-channel bundle (AW/W/B) between the camera controller master and
// the frame-buffer write slave.
interface cam_axi_wr_if #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_WDATA_WIDTH   = 32,
  parameter int AXI4_ID_WIDTH      = 16
);
  logic [AXI4_ID_WIDTH-1:0]      aw_id_i;
  logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr_i;
  logic [7:0]                    aw_len_i;
  logic [2:0]                    aw_size_i;
  logic [1:0]                    aw_burst_i;
  logic                          aw_valid_i;
  logic                          aw_ready_o;
  logic [AXI4_WDATA_WIDTH-1:0]   w_data_i;
  logic [3:0]                    w_strb_i;
  logic                          w_last_i;
  logic                          w_valid_i;
  logic                          w_ready_o;
  logic [AXI4_ID_WIDTH-1:0]      b_id_o;
  logic [1:0]                    b_resp_o;
  logic                          b_valid_o;
  logic                          b_ready_i;

  modport slave (
    input  aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_valid_i,
    output aw_ready_o,
    input  w_data_i, w_strb_i, w_last_i, w_valid_i,
    output w_ready_o,
    output b_id_o, b_resp_o, b_valid_o,
    input  b_ready_i
  );

  modport master (
    output aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_valid_i,
    input  aw_ready_o,
    output w_data_i, w_strb_i, w_last_i, w_valid_i,
    input  w_ready_o,
    input  b_id_o, b_resp_o, b_valid_o,
    output b_ready_i
  );
endinterface

// File: rtl/cam_axi_wr_slave.sv
// AXI4 write slave committing camera pixel words into the frame-buffer SRAM.
// One outstanding transaction; per-beat window check; registered SRAM port.
//
// state  | meaning
// S_IDLE | aw_ready high, waiting for an address handshake
// S_DATA | w_ready high, consuming beats until len reached or w_last seen
// S_RESP | b_valid high, response held until b_ready
module cam_axi_wr_slave #(
  parameter int                              AXI4_ADDRESS_WIDTH = 32,
  parameter int                              AXI4_WDATA_WIDTH   = 32,
  parameter int                              AXI4_ID_WIDTH      = 16,
  parameter logic [AXI4_ADDRESS_WIDTH-1:0]   BASE_ADDR          = 32'h0010_0000,
  parameter int                              MEM_DEPTH          = 4096,
  localparam int                             MEM_AW             = $clog2(MEM_DEPTH)
) (
  input  logic                        iclk,
  input  logic                        rst,
  cam_axi_wr_if.slave                 axi,
  output logic                        mem_we_o,
  output logic [MEM_AW-1:0]           mem_addr_o,
  output logic [AXI4_WDATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]                  mem_be_o,
  output logic [31:0]                 wr_beats_o,
  output logic [15:0]                 err_cnt_o
);
  localparam int AW = AXI4_ADDRESS_WIDTH;
  localparam logic [AW:0] WIN_SPAN = (AW+1)'(4 * MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t                      state_q, state_d;
  logic [AXI4_ID_WIDTH-1:0]    id_q, id_d;
  logic [AW-1:0]               addr_q, addr_d;
  logic [7:0]                  len_q, len_d;
  logic [7:0]                  beat_cnt_q, beat_cnt_d;
  logic                        incr_q, incr_d;
  logic                        prot_err_q, prot_err_d;
  logic                        dec_err_q, dec_err_d;
  logic                        aw_ready_q, aw_ready_d;
  logic                        w_ready_q, w_ready_d;
  logic                        b_valid_q, b_valid_d;
  logic [1:0]                  b_resp_q, b_resp_d;
  logic [AXI4_ID_WIDTH-1:0]    b_id_q, b_id_d;
  logic                        mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]           mem_addr_q, mem_addr_d;
  logic [AXI4_WDATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]                  mem_be_q, mem_be_d;
  logic [31:0]                 wr_beats_q, wr_beats_d;
  logic [15:0]                 err_cnt_q, err_cnt_d;

  logic          aw_hs, w_hs, b_hs;
  logic [AW-1:0] off;
  logic          in_win, last_beat, last_mismatch;

  always_comb begin
    aw_hs = axi.aw_valid_i & aw_ready_q;
    w_hs  = axi.w_valid_i & w_ready_q;
    b_hs  = b_valid_q & axi.b_ready_i;
    // With BASE_ADDR word aligned, the low two address bits never change the word index.
    off           = addr_q - BASE_ADDR;
    in_win        = (addr_q >= BASE_ADDR) && ({1'b0, off} < WIN_SPAN);
    last_beat     = (beat_cnt_q == len_q);
    last_mismatch = (axi.w_last_i != last_beat);

    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    incr_d      = incr_q;
    prot_err_d  = prot_err_q;
    dec_err_d   = dec_err_q;
    aw_ready_d  = aw_ready_q;
    w_ready_d   = w_ready_q;
    b_valid_d   = b_valid_q;
    b_resp_d    = b_resp_q;
    b_id_d      = b_id_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    wr_beats_d  = wr_beats_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        aw_ready_d = 1'b1;
        if (aw_hs) begin
          id_d       = axi.aw_id_i;
          addr_d     = axi.aw_addr_i;
          len_d      = axi.aw_len_i;
          incr_d     = (axi.aw_burst_i == 2'b01);
          prot_err_d = (axi.aw_size_i != 3'd2) || (axi.aw_burst_i == 2'b10);
          dec_err_d  = 1'b0;
          beat_cnt_d = 8'd0;
          aw_ready_d = 1'b0;
          w_ready_d  = 1'b1;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (incr_q) addr_d = addr_q + AW'(4);
          if (!in_win) dec_err_d = 1'b1;
          if (!prot_err_q && in_win) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = off[MEM_AW+1:2];
            mem_wdata_d = axi.w_data_i;
            mem_be_d    = axi.w_strb_i;
            wr_beats_d  = wr_beats_q + 32'd1;
          end
          // A mismatch can only occur on the ending beat, so it needs no flag.
          if (last_beat || axi.w_last_i) begin
            w_ready_d = 1'b0;
            b_valid_d = 1'b1;
            b_id_d    = id_q;
            if (prot_err_q || last_mismatch) b_resp_d = 2'b10;
            else if (dec_err_q || !in_win)   b_resp_d = 2'b11;
            else                             b_resp_d = 2'b00;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (b_hs) begin
          b_valid_d  = 1'b0;
          aw_ready_d = 1'b1;
          if (b_resp_q != 2'b00 && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      incr_q      <= 1'b0;
      prot_err_q  <= 1'b0;
      dec_err_q   <= 1'b0;
      aw_ready_q  <= 1'b0;
      w_ready_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      b_resp_q    <= '0;
      b_id_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      wr_beats_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      incr_q      <= incr_d;
      prot_err_q  <= prot_err_d;
      dec_err_q   <= dec_err_d;
      aw_ready_q  <= aw_ready_d;
      w_ready_q   <= w_ready_d;
      b_valid_q   <= b_valid_d;
      b_resp_q    <= b_resp_d;
      b_id_q      <= b_id_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      wr_beats_q  <= wr_beats_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign axi.aw_ready_o = aw_ready_q;
  assign axi.w_ready_o  = w_ready_q;
  assign axi.b_valid_o  = b_valid_q;
  assign axi.b_resp_o   = b_resp_q;
  assign axi.b_id_o     = b_id_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign mem_be_o       = mem_be_q;
  assign wr_beats_o     = wr_beats_q;
  assign err_cnt_o      = err_cnt_q;
endmodule

// File: doc/cam_axi_wr_slave.md
Name: cam_axi_wr_slave

Overview:
AXI4 write-channel slave that terminates the camera controller's AXI write master and commits captured pixel words into an on-chip frame-buffer SRAM.
- Accepts single-beat and INCR/FIXED bursts, checks each beat against a fixed address window, drives a registered SRAM write port, and returns a B response per transaction.
- Sits directly downstream of camera_ctrl's aw/w/b ports.

Parameters:
AXI4_ADDRESS_WIDTH, 32, AXI address width
AXI4_WDATA_WIDTH, 32, data width (fixed 32; 4 byte lanes)
AXI4_ID_WIDTH, 16, transaction ID width
BASE_ADDR, 32'h0010_0000, byte address of frame-buffer word 0
MEM_DEPTH, 4096, frame-buffer depth in words; MEM_AW = clog2(MEM_DEPTH) is a derived localparam

Ports:
iclk  in  1  system clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
aw_id_i  in  AXI4_ID_WIDTH  write address ID
aw_addr_i  in  AXI4_ADDRESS_WIDTH  burst start byte address
aw_len_i  in  8  beats minus one
aw_size_i  in  3  beat size; only 3'd2 is legal
aw_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP (unsupported)
aw_valid_i  in  1  address valid
aw_ready_o  out  1  address ready
w_data_i  in  32  write data
w_strb_i  in  4  byte strobes
w_last_i  in  1  last beat
w_valid_i  in  1  data valid
w_ready_o  out  1  data ready
b_id_o  out  AXI4_ID_WIDTH  echoed aw_id
b_resp_o  out  2  00 OKAY, 10 SLVERR, 11 DECERR
b_valid_o  out  1  response valid
b_ready_i  in  1  response ready
mem_we_o  out  1  SRAM write strobe, one cycle per committed beat
mem_addr_o  out  MEM_AW  SRAM word address
mem_wdata_o  out  32  SRAM write data
mem_be_o  out  4  SRAM byte enables (= w_strb)
wr_beats_o  out  32  committed-write counter, wraps
err_cnt_o  out  16  non-OKAY response counter, saturates at 16'hFFFF

Behaviour:
- Reset (async, rst=1): state IDLE; aw_ready_o, w_ready_o, b_valid_o, mem_we_o = 0; b_resp_o, b_id_o, mem_addr_o, mem_wdata_o, mem_be_o, wr_beats_o, err_cnt_o = 0. Reset mid-burst abandons the burst; no response is issued.
- Registered outputs throughout. aw_ready_o rises the first cycle after rst deasserts.
- States:
  - IDLE: aw_ready_o=1. On aw handshake at cycle N, capture id/addr/len/size/burst and clear beat counter and error flags. At N+1: DATA, aw_ready_o=0, w_ready_o=1.
  - DATA: w_ready_o=1. Each w handshake at cycle M is one beat. The burst ends on the first beat where beat_cnt==len OR w_last_i=1. At M+1 after the ending beat: RESP, w_ready_o=0, b_valid_o=1.
  - RESP: b_valid_o, b_id_o, b_resp_o held stable until b_ready_i. Handshake at cycle K gives b_valid_o=0 and IDLE with aw_ready_o=1 at K+1. Minimum transaction = 3 cycles plus 1 turnaround.
- Protocol error: aw_size_i!=2 or aw_burst_i==WRAP.
  - All beats are still consumed; none is written.
  - Response is SLVERR.
- Last mismatch: w_last_i=1 while beat_cnt<len, or w_last_i=0 on beat_cnt==len.
  - Beats are still written normally.
  - Response is SLVERR; the burst ends on that beat.
- Window check, per beat: beat address A is in window iff BASE_ADDR <= A < BASE_ADDR + 4*MEM_DEPTH.
  - Out-of-window beats are suppressed and flag DECERR.
  - In-window beats of the same burst are still written.
- Addressing: low two address bits are ignored. INCR adds 4 per beat with 32-bit wraparound; FIXED keeps A constant. Word address = (A - BASE_ADDR) >> 2.
- Response priority: SLVERR > DECERR > OKAY.
- SRAM write: a committed beat handshaken at M gives mem_we_o=1 at M+1 with that beat's addr/data/be. wr_beats_o increments in the same cycle. A beat with w_strb_i=0 is still committed and counted.
- err_cnt_o increments on each b handshake with b_resp_o!=OKAY, saturating.
- w_valid_i while in IDLE or RESP is ignored (w_ready_o=0). aw_valid_i outside IDLE waits; there is one outstanding transaction only.

Test Plan:
- Single beat: aw_addr=0x0010_0000, len=0, size=2, INCR, id=0x5; w_data=0x04030201, strb=F, last=1 -> mem_we one cycle at mem_addr=0, wdata 0x04030201; b_resp=00, b_id=0x5; wr_beats=1.
- INCR len=3 at 0x0010_0008, data 1..4 -> mem_addr 2,3,4,5 on consecutive writes; OKAY; wr_beats=4. Repeat with FIXED -> four writes all at mem_addr 2.
- Window straddle: INCR len=1 at 0x0010_3FFC, MEM_DEPTH=4096 -> one write at mem_addr 4095, second beat suppressed; b_resp=11; err_cnt=1.
- Protocol errors: WRAP burst len=3 -> 4 beats accepted, no mem_we, SLVERR. Separately, INCR len=3 with w_last on beat 1 -> 2 writes, SLVERR, next aw accepted.
- Backpressure: hold b_ready=0 for 10 cycles after b_valid -> b_valid/b_resp/b_id stable and aw_ready=0 throughout; b_ready=1 -> aw_ready=1 next cycle.
- Reset mid-burst: assert rst after beat 1 of len=3 -> all outputs return to reset values with no B response; a fresh single-beat write after release completes OKAY.
